// File: rtl/caravel_lite.sv
// caravel_lite: checkpoint SoC stand-in. Boots a 4-byte parameter block from
// SPI flash (read cmd 0x03 @ 0x000000), then emits start + i*step checkpoint
// words on mprj_io[31:16], echoing each low byte over an 8N1 UART on mprj_io[6].
// Ports:
//   clock, resetb      system clock, async active-low reset
//   gpio               status, 1 once the pass marker 0xAB51 is driven
//   mprj_io[37:0]      [31:16] checkpoint word, [6] UART TX, rest high-Z
//   flash_csb/clk/io0  SPI master outputs (mode 0), flash_io1 = MISO
module caravel_lite #(
  parameter int unsigned BOOT_DELAY   = 16,
  parameter int unsigned HOLD_CYCLES  = 64,
  parameter int unsigned CLKS_PER_BIT = 4167
) (
  input  logic        clock,
  input  logic        resetb,
  output logic        gpio,
  inout  wire  [37:0] mprj_io,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0] FLASH_CMD = 32'h0300_0000;
  localparam logic [15:0] CK_START  = 16'hAB40;
  localparam logic [15:0] CK_PASS   = 16'hAB51;

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_XFER  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_PASS  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ph_q, ph_d;
  logic [31:0]      sh_q, sh_d;
  logic [15:0]      val_q, val_d;
  logic [7:0]       idx_q, idx_d;
  logic [15:0]      ckpt_q, ckpt_d;
  logic             gpio_q, gpio_d;
  logic             csb_q, csb_d;
  logic             fclk_q, fclk_d;
  logic             io0_q, io0_d;
  logic             tx_q, tx_d;
  logic             tx_busy_q, tx_busy_d;
  logic [8:0]       tx_sh_q, tx_sh_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;

  logic             uart_start_c;
  logic [7:0]       uart_byte_c;
  logic             uart_idle_c;
  logic [15:0]      start_c;
  logic [7:0]       step_c;
  logic [7:0]       count_c;
  logic [15:0]      val_nxt_c;

  // Parameter block as shifted in: byte0 lands in the top byte.
  assign start_c   = {sh_q[23:16], sh_q[31:24]};
  assign step_c    = sh_q[15:8];
  assign count_c   = sh_q[7:0];
  assign val_nxt_c = val_q + {8'h00, step_c};

  // Idle also on the last clock of the stop bit, so the next frame starts back-to-back.
  assign uart_idle_c = !tx_busy_q || ((bit_q == 4'd9) && (baud_q == BAUD_LAST));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ph_d         = ph_q;
    sh_d         = sh_q;
    val_d        = val_q;
    idx_d        = idx_q;
    ckpt_d       = ckpt_q;
    gpio_d       = gpio_q;
    csb_d        = csb_q;
    fclk_d       = fclk_q;
    io0_d        = io0_q;
    tx_d         = tx_q;
    tx_busy_d    = tx_busy_q;
    tx_sh_d      = tx_sh_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    uart_start_c = 1'b0;
    uart_byte_c  = 8'h00;

    case (state_q)
      S_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = S_XFER;
          cnt_d   = '0;
          ph_d    = 8'd0;
          csb_d   = 1'b0;
          io0_d   = FLASH_CMD[31];
          sh_d    = FLASH_CMD << 1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // ph_q even -> SPI rise, odd -> fall; 128 half-periods, then csb up, then START.
      S_XFER: begin
        ph_d = ph_q + 8'd1;
        if (ph_q < 8'd128) begin
          if (!ph_q[0]) begin
            fclk_d = 1'b1;
            if (ph_q >= 8'd64) sh_d = {sh_q[30:0], flash_io1};
          end else begin
            fclk_d = 1'b0;
            if (ph_q < 8'd64) begin
              io0_d = sh_q[31];
              sh_d  = sh_q << 1;
            end else begin
              io0_d = 1'b0;
            end
          end
        end else if (ph_q == 8'd128) begin
          csb_d = 1'b1;
        end else begin
          state_d = S_START;
          ckpt_d  = CK_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (count_c == 8'd0) begin
            state_d = S_PASS;
            ckpt_d  = CK_PASS;
            gpio_d  = 1'b1;
          end else begin
            state_d      = S_EMIT;
            ckpt_d       = start_c;
            val_d        = start_c;
            idx_d        = 8'd0;
            uart_start_c = 1'b1;
            uart_byte_c  = start_c[7:0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (cnt_q != HOLD_LAST) cnt_d = cnt_q + 1'b1;
        if ((cnt_q == HOLD_LAST) && uart_idle_c) begin
          cnt_d = '0;
          if (idx_q == (count_c - 8'd1)) begin
            state_d = S_PASS;
            ckpt_d  = CK_PASS;
            gpio_d  = 1'b1;
          end else begin
            val_d        = val_nxt_c;
            ckpt_d       = val_nxt_c;
            idx_d        = idx_q + 8'd1;
            uart_start_c = 1'b1;
            uart_byte_c  = val_nxt_c[7:0];
          end
        end
      end
      S_PASS:  state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_BOOT;
    endcase

    // UART transmitter: tx_sh holds {stop, data}, shifted out LSB first.
    if (tx_busy_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_d    = tx_sh_q[0];
          tx_sh_d = {1'b1, tx_sh_q[8:1]};
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
    if (uart_start_c) begin
      tx_busy_d = 1'b1;
      tx_d      = 1'b0;
      tx_sh_d   = {1'b1, uart_byte_c};
      baud_d    = '0;
      bit_d     = 4'd0;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_BOOT;
      cnt_q     <= '0;
      ph_q      <= 8'd0;
      sh_q      <= 32'd0;
      val_q     <= 16'd0;
      idx_q     <= 8'd0;
      ckpt_q    <= 16'd0;
      gpio_q    <= 1'b0;
      csb_q     <= 1'b1;
      fclk_q    <= 1'b0;
      io0_q     <= 1'b0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_sh_q   <= 9'h1FF;
      baud_q    <= '0;
      bit_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      sh_q      <= sh_d;
      val_q     <= val_d;
      idx_q     <= idx_d;
      ckpt_q    <= ckpt_d;
      gpio_q    <= gpio_d;
      csb_q     <= csb_d;
      fclk_q    <= fclk_d;
      io0_q     <= io0_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
      tx_sh_q   <= tx_sh_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
    end
  end

  assign gpio      = gpio_q;
  assign flash_csb = csb_q;
  assign flash_clk = fclk_q;
  assign flash_io0 = io0_q;

  assign mprj_io[37:32] = 6'bz;
  assign mprj_io[31:16] = ckpt_q;
  assign mprj_io[15:7]  = 9'bz;
  assign mprj_io[6]     = tx_q;
  assign mprj_io[5:0]   = 6'bz;

endmodule

// File: tb/tb_caravel_lite.sv
// Bench for caravel_lite: flash model, checkpoint/UART/SPI monitors, and a
// reference model of the checkpoint and UART byte sequences.
module tb_caravel_lite;

  localparam int BOOT = 16;
  localparam int HOLD = 64;
  localparam int CPB  = 8;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        flash_io1 = 1'b0;
  wire         gpio;
  wire  [37:0] mprj_io;
  wire         flash_csb;
  wire         flash_clk;
  wire         flash_io0;
  wire         tx_w = mprj_io[6];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  caravel_lite #(
    .BOOT_DELAY  (BOOT),
    .HOLD_CYCLES (HOLD),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock    (clock),
    .resetb   (resetb),
    .gpio     (gpio),
    .mprj_io  (mprj_io),
    .flash_csb(flash_csb),
    .flash_clk(flash_clk),
    .flash_io0(flash_io0),
    .flash_io1(flash_io1)
  );

  // Monitor state, cleared while reset is asserted.
  logic [31:0] flash_data = 32'd0;
  int          cyc = 0;
  logic [15:0] ck;
  logic [15:0] prev_ck = 16'd0;
  int          last_change = 0;
  logic [15:0] obs_q[$];
  int          ch_q[$];
  logic [7:0]  rx_q[$];
  int          fs_q[$];
  int          hold_err = 0, gap_err = 0, frame_err = 0, spi_err = 0;
  int          rises = 0, falls = 0, csb_falls = 0;
  logic [31:0] mosi = 32'd0;
  int          csb_rise_cyc = -100, ab40_cyc = -1, gpio_rise_cyc = -1;
  logic        fr_active = 1'b0;
  int          fr_pos = 0;
  logic [79:0] fr_s = 80'd0;
  logic [7:0]  fr_byte;
  logic        fr_bad;
  logic        prev_fclk = 1'b0, prev_csb = 1'b1, prev_gpio = 1'b0;

  always @(negedge clock) begin
    cyc++;
    ck = mprj_io[31:16];
    if (!resetb) begin
      obs_q.delete(); ch_q.delete(); rx_q.delete(); fs_q.delete();
      hold_err = 0; gap_err = 0; frame_err = 0; spi_err = 0;
      rises = 0; falls = 0; csb_falls = 0; mosi = 32'd0;
      csb_rise_cyc = -100; ab40_cyc = -1; gpio_rise_cyc = -1;
      fr_active = 1'b0;
      last_change = cyc;
    end else begin
      // checkpoint word changes; a new word must not cut a UART frame short
      if (ck !== prev_ck) begin
        obs_q.push_back(ck);
        ch_q.push_back(cyc);
        if (ck != 16'd0 && prev_ck != 16'd0 && (cyc - last_change) < HOLD) hold_err++;
        if (fr_active) gap_err++;
        if (ck == 16'hAB40) ab40_cyc = cyc;
        last_change = cyc;
      end
      if (gpio === 1'b1 && prev_gpio === 1'b0) gpio_rise_cyc = cyc;
      // UART receiver: one sample per clock over an 80-clock frame
      if (fr_active) begin
        fr_pos++;
        fr_s[fr_pos] = tx_w;
        if (fr_pos == 10 * CPB - 1) begin
          fr_bad = 1'b0;
          for (int k = 0; k < CPB; k++) if (fr_s[k] !== 1'b0) fr_bad = 1'b1;
          for (int b = 0; b < 8; b++) begin
            fr_byte[b] = fr_s[CPB + CPB * b];
            for (int k = 0; k < CPB; k++)
              if (fr_s[CPB + CPB * b + k] !== fr_s[CPB + CPB * b]) fr_bad = 1'b1;
          end
          for (int k = 9 * CPB; k < 10 * CPB; k++) if (fr_s[k] !== 1'b1) fr_bad = 1'b1;
          if (fr_bad) frame_err++;
          rx_q.push_back(fr_byte);
          fr_active = 1'b0;
        end
      end else if (tx_w === 1'b0) begin
        fr_active = 1'b1;
        fr_pos = 0;
        fr_s = 80'd0;
        fs_q.push_back(cyc);
      end
      // SPI monitor and flash model
      if (flash_csb === 1'b0 && prev_csb === 1'b1) begin
        csb_falls++; rises = 0; falls = 0; flash_io1 = 1'b0;
      end
      if (flash_csb === 1'b1 && prev_csb === 1'b0) csb_rise_cyc = cyc;
      if (flash_clk === 1'b1 && prev_fclk === 1'b0) begin
        rises++;
        if (rises <= 32) mosi = {mosi[30:0], flash_io0};
        if (flash_csb !== 1'b0) spi_err++;
      end
      if (flash_clk === 1'b0 && prev_fclk === 1'b1) begin
        falls++;
        if (falls >= 32 && falls < 64) flash_io1 = flash_data[63 - falls];
      end
      if (flash_csb === 1'b1 && flash_clk !== 1'b0) spi_err++;
    end
    prev_ck   = ck;
    prev_fclk = flash_clk;
    prev_csb  = flash_csb;
    prev_gpio = gpio;
  end

  task automatic test_reset();
    #1 resetb = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (mprj_io[31:16] !== 16'h0000) begin errors++; $display("FAIL reset_ckpt got %h exp 0000", mprj_io[31:16]); end
    checks++; if (tx_w !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx_w); end
    checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL reset_csb got %b exp 1", flash_csb); end
    checks++; if (flash_clk !== 1'b0) begin errors++; $display("FAIL reset_fclk got %b exp 0", flash_clk); end
    checks++; if (flash_io0 !== 1'b0) begin errors++; $display("FAIL reset_io0 got %b exp 0", flash_io0); end
    checks++; if (gpio !== 1'b0) begin errors++; $display("FAIL reset_gpio got %b exp 0", gpio); end
  endtask

  // Full boot + emit run for one flash parameter block, checked against the model.
  task automatic test_sequence(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
    logic [15:0] exp_ck[$];
    logic [7:0]  exp_rx[$];
    logic [15:0] start;
    logic [15:0] v;
    int n, bad, first, sz;
    flash_data = {b0, b1, b2, b3};
    start = {b1, b0};
    exp_ck.push_back(16'hAB40);
    for (int i = 0; i < int'(b3); i++) begin
      v = 16'(int'(start) + i * int'(b2));
      exp_ck.push_back(v);
      exp_rx.push_back(v[7:0]);
    end
    exp_ck.push_back(16'hAB51);

    @(posedge clock); #2 resetb = 1'b0;
    repeat (3) @(negedge clock);
    #2 resetb = 1'b1;
    n = 0;
    while (gpio !== 1'b1 && n < 8000) begin @(negedge clock); n++; end
    repeat (4) @(negedge clock);
    #1;

    checks++; if (gpio !== 1'b1) begin errors++; $display("FAIL seq_done gpio=%b after %0d cycles exp 1", gpio, n); end
    checks++; if (obs_q.size() != exp_ck.size()) begin errors++; $display("FAIL seq_len got %0d words exp %0d", obs_q.size(), exp_ck.size()); end
    bad = 0; first = -1;
    sz = (obs_q.size() < exp_ck.size()) ? obs_q.size() : exp_ck.size();
    for (int i = 0; i < sz; i++) if (obs_q[i] !== exp_ck[i]) begin bad++; if (first < 0) first = i; end
    checks++; if (bad != 0) begin errors++; $display("FAIL seq_words idx %0d got %h exp %h", first, obs_q[first], exp_ck[first]); end
    checks++; if (rx_q.size() != exp_rx.size()) begin errors++; $display("FAIL uart_count got %0d exp %0d", rx_q.size(), exp_rx.size()); end
    bad = 0; first = -1;
    sz = (rx_q.size() < exp_rx.size()) ? rx_q.size() : exp_rx.size();
    for (int i = 0; i < sz; i++) if (rx_q[i] !== exp_rx[i]) begin bad++; if (first < 0) first = i; end
    checks++; if (bad != 0) begin errors++; $display("FAIL uart_bytes idx %0d got %h exp %h", first, rx_q[first], exp_rx[first]); end
    checks++; if (mosi !== 32'h0300_0000) begin errors++; $display("FAIL spi_mosi got %h exp 03000000", mosi); end
    checks++; if (rises != 64) begin errors++; $display("FAIL spi_rises got %0d exp 64", rises); end
    checks++; if (csb_falls != 1 || spi_err != 0) begin errors++; $display("FAIL spi_csb falls %0d errs %0d exp 1/0", csb_falls, spi_err); end
    checks++; if (ab40_cyc - csb_rise_cyc != 1) begin errors++; $display("FAIL ab40_lat got %0d exp 1", ab40_cyc - csb_rise_cyc); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL hold_time violations %0d exp 0", hold_err); end
    checks++; if (gap_err != 0 || frame_err != 0) begin errors++; $display("FAIL uart_frame gap %0d bad %0d exp 0/0", gap_err, frame_err); end
    if (ch_q.size() == exp_ck.size()) begin
      checks++; if (gpio_rise_cyc != ch_q[ch_q.size() - 1]) begin errors++; $display("FAIL gpio_align got %0d exp %0d", gpio_rise_cyc, ch_q[ch_q.size() - 1]); end
      if (b3 != 8'd0 && fs_q.size() > 0) begin
        checks++; if (fs_q[0] != ch_q[1]) begin errors++; $display("FAIL uart_start_align got %0d exp %0d", fs_q[0], ch_q[1]); end
      end
    end
    sz = obs_q.size();
    repeat (60) @(negedge clock);
    #1;
    checks++;
    if (obs_q.size() != sz || mprj_io[31:16] !== 16'hAB51 || gpio !== 1'b1 || tx_w !== 1'b1 || flash_csb !== 1'b1) begin
      errors++; $display("FAIL done_hold ck %h gpio %b tx %b csb %b exp AB51/1/1/1", mprj_io[31:16], gpio, tx_w, flash_csb);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++)
      test_sequence(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 4)));
  endtask

  // Reset during the second EMIT word, then the whole sequence must replay.
  task automatic test_reset_mid_emit();
    int n;
    flash_data = 32'h3E00_0604;
    @(posedge clock); #2 resetb = 1'b0;
    repeat (2) @(negedge clock);
    #2 resetb = 1'b1;
    n = 0;
    while (mprj_io[31:16] !== 16'h0044 && n < 4000) begin @(negedge clock); n++; end
    checks++; if (mprj_io[31:16] !== 16'h0044) begin errors++; $display("FAIL mid_reach got %h exp 0044", mprj_io[31:16]); end
    repeat (20) @(negedge clock);
    @(posedge clock); #2 resetb = 1'b0;
    #1;
    checks++;
    if (mprj_io[31:16] !== 16'h0000 || tx_w !== 1'b1 || gpio !== 1'b0 || flash_csb !== 1'b1 || flash_clk !== 1'b0) begin
      errors++; $display("FAIL mid_reset ck %h tx %b gpio %b csb %b fclk %b exp 0000/1/0/1/0", mprj_io[31:16], tx_w, gpio, flash_csb, flash_clk);
    end
    test_sequence(8'h3E, 8'h00, 8'h06, 8'h04);
  endtask

  // Reset landing in the middle of the flash transfer must release csb.
  task automatic test_reset_mid_flash();
    @(posedge clock); #2 resetb = 1'b0;
    repeat (2) @(negedge clock);
    #2 resetb = 1'b1;
    repeat (BOOT + 40) @(negedge clock);
    checks++; if (flash_csb !== 1'b0) begin errors++; $display("FAIL flash_active csb got %b exp 0", flash_csb); end
    @(posedge clock); #2 resetb = 1'b0;
    #1;
    checks++; if (flash_csb !== 1'b1 || flash_clk !== 1'b0 || flash_io0 !== 1'b0) begin
      errors++; $display("FAIL flash_abort csb %b fclk %b io0 %b exp 1/0/0", flash_csb, flash_clk, flash_io0);
    end
  endtask

  initial begin
    test_reset();
    test_sequence(8'h3E, 8'h00, 8'h06, 8'h04);
    test_sequence(8'h00, 8'h00, 8'h09, 8'h00);
    test_sequence(8'hFE, 8'hFF, 8'h04, 8'h02);
    test_reset_mid_emit();
    test_reset_mid_flash();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
